// File: rtl/reg_cmd_pkg.sv
// Shared opcode and state encodings for the register command sequencer.
// Optional rotate opcodes are enabled by REG_CMD_SEQ_ROTATE_EN in reg_cmd_seq.
package reg_cmd_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OP_CLR  = 3'd0;
    localparam logic [OP_W-1:0] OP_LOAD = 3'd1;
    localparam logic [OP_W-1:0] OP_INC  = 3'd2;
    localparam logic [OP_W-1:0] OP_DEC  = 3'd3;
    localparam logic [OP_W-1:0] OP_SHR  = 3'd4;
    localparam logic [OP_W-1:0] OP_SHL  = 3'd5;
    localparam logic [OP_W-1:0] OP_ROR  = 3'd6;
    localparam logic [OP_W-1:0] OP_ROL  = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/reg_cmd_seq_if.sv
// Command handshake bundle between a datapath controller (master) and reg_cmd_seq (slave).
// A command transfers on a clock edge with cmd_valid && cmd_ready; fields must hold until then.
interface reg_cmd_seq_if #(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
);
    import reg_cmd_pkg::*;

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [OP_W-1:0]       cmd_op;
    logic [CNT_WIDTH-1:0]  cmd_count;
    logic                  cmd_fill;
    logic [DATA_WIDTH-1:0] cmd_data;

    modport master (
        output cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_data,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_count, cmd_fill, cmd_data,
        output cmd_ready
    );

endinterface

// File: rtl/seq_reg.sv
// General-purpose sequential register: clear, load, inc, dec, shift right/left with serial fill.
// Latency: control strobes take effect at the next rising edge; no backpressure.
// Strobes are expected one-hot; priority order below only matters if that is violated.
module seq_reg #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cl,
    input  logic                  ld,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  sr,
    input  logic                  sl,
    input  logic                  ir,
    input  logic                  il,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic [DATA_WIDTH-1:0] q
);

    localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (!rst_n)   q <= '0;
        else if (cl)  q <= '0;
        else if (ld)  q <= ld_data;
        else if (inc) q <= q + ONE;
        else if (dec) q <= q - ONE;
        else if (sr)  q <= {ir, q[DATA_WIDTH-1:1]};
        else if (sl)  q <= {q[DATA_WIDTH-2:0], il};
    end

endmodule

// File: rtl/reg_cmd_seq.sv
// Turns one register command (op + repeat count) into N cycles of one-hot register strobes.
// Latency: strobes from the accept edge for N cycles, then a 1-cycle done; rotates need REG_CMD_SEQ_ROTATE_EN.
// Backpressure: cmd_ready only in IDLE, so back-to-back commands see a 2-cycle gap.
module reg_cmd_seq
    import reg_cmd_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    reg_cmd_seq_if.slave          cmd,
    input  logic                  abort,
    input  logic [DATA_WIDTH-1:0] reg_out,
    output logic                  cl,
    output logic                  ld,
    output logic                  inc,
    output logic                  dec,
    output logic                  sr,
    output logic                  sl,
    output logic                  ir,
    output logic                  il,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic                  aborted
);

`ifdef REG_CMD_SEQ_ROTATE_EN
    localparam bit ROT_EN = 1'b1;
`else
    localparam bit ROT_EN = 1'b0;
`endif

    // One extra counter bit so an all-ones cmd_count still yields 2^CNT_WIDTH repetitions.
    localparam logic [CNT_WIDTH:0] CNT_ONE = (CNT_WIDTH+1)'(1);

    state_e                state;
    logic [OP_W-1:0]       op_q;
    logic                  fill_q;
    logic [CNT_WIDTH:0]    cnt_q;
    logic [DATA_WIDTH-1:0] ld_data_q;
    logic                  err_q;
    logic                  aborted_q;
    logic                  run;
    logic                  cmd_legal;
    logic                  single_shot;

    assign cmd_legal   = ROT_EN || (cmd.cmd_op <= OP_SHL);
    assign single_shot = (cmd.cmd_op == OP_CLR) || (cmd.cmd_op == OP_LOAD);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_CLR;
            fill_q    <= 1'b0;
            cnt_q     <= '0;
            ld_data_q <= '0;
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cmd.cmd_valid) begin
                        op_q      <= cmd.cmd_op;
                        fill_q    <= cmd.cmd_fill;
                        ld_data_q <= cmd.cmd_data;
                        cnt_q     <= single_shot ? CNT_ONE : ({1'b0, cmd.cmd_count} + CNT_ONE);
                        aborted_q <= 1'b0;
                        err_q     <= !cmd_legal;
                        state     <= cmd_legal ? ST_RUN : ST_DONE;
                    end
                end
                ST_RUN: begin
                    // Final repetition wins over a coincident abort.
                    if (cnt_q == CNT_ONE) begin
                        state <= ST_DONE;
                    end else if (abort) begin
                        state     <= ST_DONE;
                        aborted_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                ST_DONE: begin
                    state     <= ST_IDLE;
                    err_q     <= 1'b0;
                    aborted_q <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign run           = (state == ST_RUN);
    assign busy          = run;
    assign done          = (state == ST_DONE);
    assign cmd.cmd_ready = (state == ST_IDLE);
    assign err           = err_q;
    assign aborted       = aborted_q;
    assign ld_data       = ld_data_q;

    assign cl  = run && (op_q == OP_CLR);
    assign ld  = run && (op_q == OP_LOAD);
    assign inc = run && (op_q == OP_INC);
    assign dec = run && (op_q == OP_DEC);

`ifdef REG_CMD_SEQ_ROTATE_EN
    assign sr = run && ((op_q == OP_SHR) || (op_q == OP_ROR));
    assign sl = run && ((op_q == OP_SHL) || (op_q == OP_ROL));
    // Rotates recirculate the register's own end bit as the serial input.
    assign ir = run && ((op_q == OP_SHR) ? fill_q : ((op_q == OP_ROR) && reg_out[0]));
    assign il = run && ((op_q == OP_SHL) ? fill_q : ((op_q == OP_ROL) && reg_out[DATA_WIDTH-1]));
`else
    logic unused_reg_out;
    assign unused_reg_out = ^reg_out;
    assign sr = run && (op_q == OP_SHR);
    assign sl = run && (op_q == OP_SHL);
    assign ir = run && (op_q == OP_SHR) && fill_q;
    assign il = run && (op_q == OP_SHL) && fill_q;
`endif

endmodule

// File: tb/tb_reg_cmd_seq.sv
// Randomized scoreboard bench for reg_cmd_seq driving a seq_reg instance.
// Rotate expectations follow REG_CMD_SEQ_ROTATE_EN when the bench is built with it.
module tb_reg_cmd_seq;
    import reg_cmd_pkg::*;

    localparam int DW = 16;
    localparam int CW = 4;
`ifdef REG_CMD_SEQ_ROTATE_EN
    localparam bit ROT = 1'b1;
`else
    localparam bit ROT = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          abort = 1'b0;
    logic          cl, ld, inc, dec, sr, sl, ir, il;
    logic          busy, done, err, aborted;
    logic [DW-1:0] ld_data;
    logic [DW-1:0] reg_q;

    reg_cmd_seq_if #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) cmd_if ();

    reg_cmd_seq #(.DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst_n(rst_n), .cmd(cmd_if), .abort(abort), .reg_out(reg_q),
        .cl(cl), .ld(ld), .inc(inc), .dec(dec), .sr(sr), .sl(sl), .ir(ir), .il(il),
        .ld_data(ld_data), .busy(busy), .done(done), .err(err), .aborted(aborted)
    );

    seq_reg #(.DATA_WIDTH(DW)) u_reg (
        .clk(clk), .rst_n(rst_n), .cl(cl), .ld(ld), .inc(inc), .dec(dec),
        .sr(sr), .sl(sl), .ir(ir), .il(il), .ld_data(ld_data), .q(reg_q)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [2:0]    op;
        logic          fill;
        logic [DW-1:0] data;
        int            performed;
        int            sid;
        logic          err;
        logic          aborted;
        logic [DW-1:0] val;
        int            acc;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] m_reg = '0;

    // Reference: how many repetitions happen and what the register holds afterwards.
    function automatic exp_t model(input logic [2:0] op, input logic [CW-1:0] cnt, input logic fill,
                                   input logic [DW-1:0] data, input int ab, input logic [DW-1:0] start);
        exp_t          e;
        int            reps;
        logic [DW-1:0] v;
        e.op = op; e.fill = fill; e.data = data; e.err = 1'b0; e.aborted = 1'b0; e.acc = 0;
        reps = (op <= 3'd1) ? 1 : int'(cnt) + 1;
        if (op >= 3'd6 && !ROT) begin
            e.err = 1'b1;
            e.performed = 0;
        end else if (ab > 0 && ab < reps) begin
            e.performed = ab;
            e.aborted = 1'b1;
        end else begin
            e.performed = reps;
        end
        e.sid = (op <= 3'd3) ? int'(op) : ((op == 3'd4 || op == 3'd6) ? 4 : 5);
        v = start;
        for (int i = 0; i < e.performed; i++) begin
            case (op)
                3'd0: v = '0;
                3'd1: v = data;
                3'd2: v = v + 16'd1;
                3'd3: v = v - 16'd1;
                3'd4: v = (v >> 1) | (fill ? 16'h8000 : 16'h0000);
                3'd5: v = (v << 1) | {15'd0, fill};
                3'd6: v = (v >> 1) | (v[0] ? 16'h8000 : 16'h0000);
                default: v = (v << 1) | {15'd0, v[15]};
            endcase
        end
        e.val = v;
        return e;
    endfunction

    // Monitor: observes every cycle, pops an expectation on each done pulse.
    logic [5:0] stb;
    int         scnt = 0, bcnt = 0, sid_seen = -1;
    bit         ir_bad = 1'b0, after_done = 1'b0;
    exp_t       mon_e;
    logic       eir, eil;

    always @(negedge clk) begin
        if (!rst_n) begin
            scnt = 0; bcnt = 0; sid_seen = -1; ir_bad = 1'b0; after_done = 1'b0;
        end else begin
            if (after_done) begin
                chk("ready_after_done", {31'd0, cmd_if.cmd_ready}, 32'd1);
                after_done = 1'b0;
            end
            if (cmd_if.cmd_valid && (busy || done))
                chk("no_accept_while_busy", {31'd0, cmd_if.cmd_ready}, 32'd0);
            stb = {cl, ld, inc, dec, sr, sl};
            if (stb != 6'd0) begin
                chk("strobe_onehot", $countones(stb), 32'd1);
                scnt++;
                for (int i = 0; i < 6; i++) if (stb[5-i]) sid_seen = i;
                if (exp_q.size() > 0) begin
                    mon_e = exp_q[0];
                    eir = (mon_e.op == 3'd4) ? mon_e.fill : ((mon_e.op == 3'd6) ? reg_q[0] : 1'b0);
                    eil = (mon_e.op == 3'd5) ? mon_e.fill : ((mon_e.op == 3'd7) ? reg_q[DW-1] : 1'b0);
                    if (ir !== eir || il !== eil) ir_bad = 1'b1;
                end
            end else if (ir || il) begin
                ir_bad = 1'b1;
            end
            if (busy) bcnt++;
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_done actual=done required=no_done (cycle %0d)", cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("err", {31'd0, err}, {31'd0, mon_e.err});
                    chk("aborted", {31'd0, aborted}, {31'd0, mon_e.aborted});
                    chk("strobe_cycles", scnt, mon_e.performed);
                    chk("busy_cycles", bcnt, mon_e.performed);
                    if (mon_e.performed > 0) chk("strobe_kind", sid_seen, mon_e.sid);
                    chk("reg_value", {16'd0, reg_q}, {16'd0, mon_e.val});
                    chk("ld_data", {16'd0, ld_data}, {16'd0, mon_e.data});
                    chk("done_latency", cyc - mon_e.acc, mon_e.performed + 1);
                    chk("serial_in", {31'd0, ir_bad}, 32'd0);
                end
                scnt = 0; bcnt = 0; sid_seen = -1; ir_bad = 1'b0; after_done = 1'b1;
            end
        end
    end

    task automatic send(input logic [2:0] op, input logic [CW-1:0] cnt, input logic fill,
                        input logic [DW-1:0] data, input int ab);
        int   w;
        exp_t e;
        @(negedge clk);
        cmd_if.cmd_op = op; cmd_if.cmd_count = cnt; cmd_if.cmd_fill = fill; cmd_if.cmd_data = data;
        cmd_if.cmd_valid = 1'b1;
        w = 0;
        while (!cmd_if.cmd_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_if.cmd_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout actual=cmd_ready_low required=cmd_ready_high");
            cmd_if.cmd_valid = 1'b0;
            return;
        end
        @(posedge clk);
        e = model(op, cnt, fill, data, ab, m_reg);
        e.acc = cyc;
        m_reg = e.val;
        exp_q.push_back(e);
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_op = 3'($urandom); cmd_if.cmd_count = CW'($urandom);
        cmd_if.cmd_fill = 1'($urandom); cmd_if.cmd_data = DW'($urandom);
        if (ab > 0) begin
            repeat (ab - 1) @(negedge clk);
            abort = 1'b1;
            @(negedge clk);
            abort = 1'b0;
        end
    endtask

    initial begin
        int w;
        logic [2:0] rop;
        logic [CW-1:0] rcnt;
        int reps, rab;

        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = '0; cmd_if.cmd_count = '0;
        cmd_if.cmd_fill = 1'b0; cmd_if.cmd_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_cmd_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        chk("rst_flags", {28'd0, busy, done, err, aborted}, 32'd0);
        chk("rst_strobes", {24'd0, cl, ld, inc, dec, sr, sl, ir, il}, 32'd0);
        chk("rst_ld_data", {16'd0, ld_data}, 32'd0);
        rst_n = 1'b1;

        send(3'd1, 4'd7, 1'b0, 16'h1234, 0);
        send(3'd1, 4'd0, 1'b0, 16'hFFFE, 0);
        send(3'd2, 4'd4, 1'b0, 16'h0000, 0);
        send(3'd1, 4'd0, 1'b0, 16'h0010, 0);
        send(3'd4, 4'd2, 1'b1, 16'h0000, 0);
        send(3'd1, 4'd0, 1'b0, 16'h0001, 0);
        send(3'd5, 4'd15, 1'b0, 16'h0000, 3);
        send(3'd3, 4'd3, 1'b0, 16'h0000, 4);

        // Reset in the middle of a long shift.
        send(3'd5, 4'd15, 1'b1, 16'h0000, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrun_rst_strobes", {26'd0, cl, ld, inc, dec, sr, sl}, 32'd0);
        chk("midrun_rst_ready", {31'd0, cmd_if.cmd_ready}, 32'd1);
        chk("midrun_rst_busy", {31'd0, busy}, 32'd0);
        chk("midrun_rst_reg", {16'd0, reg_q}, 32'd0);
        exp_q.delete();
        m_reg = '0;
        @(negedge clk);
        rst_n = 1'b1;

        send(3'd1, 4'd0, 1'b0, 16'hBEEF, 0);
        send(3'd0, 4'd9, 1'b0, 16'h0000, 0);
        send(3'd1, 4'd0, 1'b0, 16'h0001, 0);
        send(3'd6, 4'd3, 1'b0, 16'h0000, 0);
        send(3'd7, 4'd2, 1'b0, 16'h0000, 0);
        send(3'd2, 4'd15, 1'b0, 16'h0000, 0);

        for (int n = 0; n < 150; n++) begin
            rop  = 3'($urandom_range(0, 7));
            rcnt = CW'($urandom);
            reps = (rop <= 3'd1) ? 1 : int'(rcnt) + 1;
            rab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, reps + 1)) : 0;
            send(rop, rcnt, 1'($urandom), DW'($urandom), rab);
        end

        w = 0;
        while (exp_q.size() > 0 && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d_pending required=0_pending", exp_q.size());
        end
        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_cmd_seq.md
Name: reg_cmd_seq

Overview:
- Command-driven sequencer that sits directly upstream of the general-purpose sequential register.
- Accepts one register command at a time over a valid/ready handshake: clear, load, increment, decrement, shift right or shift left, with a repeat count.
- Generates the register's one-hot control strobes, load data and serial fill bits cycle by cycle, then signals completion.
- Lets datapath control (e.g. shift-by-N, add-small-constant) issue a single command instead of hand-sequencing strobes.

Parameters:
- DATA_WIDTH, 16, width of load data and of the register being driven.
- CNT_WIDTH, 4, width of the repeat-count field; max repetitions = 2^CNT_WIDTH.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset, sampled on rising edge of clk.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  sequencer can accept a command.
- cmd_op  in  3  opcode: 0 CLR, 1 LOAD, 2 INC, 3 DEC, 4 SHR, 5 SHL, 6 ROR, 7 ROL.
- cmd_count  in  CNT_WIDTH  repetitions minus one (INC/DEC/shift/rotate only).
- cmd_fill  in  1  serial fill bit for SHR/SHL.
- cmd_data  in  DATA_WIDTH  load value for LOAD.
- abort  in  1  terminate a running command.
- reg_out  in  DATA_WIDTH  current value of the driven register; used only for rotates.
- cl, ld, inc, dec, sr, sl  out  1 each  register control strobes, at most one high.
- ir, il  out  1 each  serial inputs to the register.
- ld_data  out  DATA_WIDTH  register load value.
- busy  out  1  command in progress.
- done  out  1  one-cycle completion pulse.
- err  out  1  qualifies done: illegal opcode.
- aborted  out  1  qualifies done: command terminated by abort.

Behaviour:
- Reset (rst_n=0 at an edge):
  - state -> IDLE.
  - All strobes, ir, il, done, err, aborted, busy = 0; ld_data = 0; cmd_ready = 1 after that edge.
  - Reset has priority over everything, including in RUN; strobes drop at that same edge.
- States: IDLE, RUN, DONE; 2-bit encoding.
- IDLE:
  - cmd_ready=1.
  - cmd_valid&&cmd_ready at an edge latches op, fill and data.
  - Remaining count = cmd_count+1 for INC/DEC/SHR/SHL/ROR/ROL; CLR and LOAD use 1, cmd_count ignored.
  - Go to RUN, or to DONE with err=1 for an illegal opcode.
- RUN:
  - busy=1, cmd_ready=0.
  - The strobe for the latched op is high every cycle; the remaining counter decrements each edge.
  - When the remaining count reaches 1, the next edge goes to DONE.
  - N repetitions give exactly N consecutive strobe cycles.
- DONE:
  - done=1 for exactly one cycle, cmd_ready=0, busy=0.
  - err and aborted are valid only while done=1.
  - Next edge goes to IDLE.
- Latency: accept at edge E0 -> strobes high E0..EN -> done high EN..EN+1 -> cmd_ready high from EN+1. Back-to-back commands have a 2-cycle gap.
- Strobes are decoded from registered state/op only. There is no combinational path from cmd_* to the strobes.
- ld_data holds the latched cmd_data from accept until the next accept.
- ir = latched fill for SHR; il = latched fill for SHL; otherwise both 0. For ROR/ROL, see Optional Feature.
- Width/wrap:
  - The counter is CNT_WIDTH+1 bits, so cmd_count = all-ones gives 2^CNT_WIDTH repetitions without overflow.
  - Register-side wrap on INC/DEC is the register's concern.
- Abort:
  - abort=1 in RUN goes to DONE at the next edge with aborted=1.
  - The strobe is low from that edge.
  - The strobe cycle in which abort is sampled still counts as performed.
  - Abort in IDLE/DONE is ignored.
  - Abort coincident with the final repetition gives aborted=0 (normal completion wins).
- cmd_valid held in RUN/DONE is not accepted and must remain stable until accepted.

Optional Feature:
- Macro: REG_CMD_SEQ_ROTATE_EN.
- Defined:
  - Opcodes 6/7 are legal and drive sr/sl respectively.
  - ir = reg_out[0] (ROR) and il = reg_out[DATA_WIDTH-1] (ROL), combinationally, each RUN cycle.
- Undefined:
  - Opcodes 6/7 are illegal: no strobes, done with err=1 one cycle after accept.
  - reg_out is unused.

Decomposition:
- Package reg_cmd_pkg:
  - opcode localparams OP_CLR..OP_ROL;
  - state encoding ST_IDLE/ST_RUN/ST_DONE;
  - opcode width constant 3.
- Single module. The repeat counter is inline; no sub-module is warranted.
- Bench instantiates reg_cmd_seq driving a real register instance.

Test Plan:
- LOAD data=0x1234 -> ld high exactly 1 cycle, ld_data=0x1234, register=0x1234, done 1 cycle after ld, cmd_ready 1 cycle after done.
- INC count=4 from register 0xFFFE -> inc high 5 consecutive cycles, register=0x0003, done=1, err=0.
- SHR count=2 fill=1 from 0x0010 -> sr high 3 cycles, ir=1 throughout, register sequence 0x8008, 0xC004, 0xE002.
- SHL count=15 fill=0 from 0x0001, abort after 3rd strobe cycle -> sl low next cycle, done=1 aborted=1, register=0x0008; rst_n low mid-RUN in a repeat run -> strobes 0 at that edge, cmd_ready=1 after.
- CLR with cmd_count=9 -> cl high exactly 1 cycle, register=0x0000; new command offered during RUN not accepted until cmd_ready.
- op=6 count=3 on 0x0001: without macro -> no strobes, done+err one cycle after accept; with macro -> sr 4 cycles, register 0x8000, 0x4000, 0x2000, 0x1000.
